// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the quad-SPI flash read arbiter.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module flash_arb_rr
    import flash_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld = |req;
        gnt_id  = PORT_IF;
        case (req)
            2'b01:   gnt_id = PORT_IF;
            2'b10:   gnt_id = PORT_DM;
            2'b11:   gnt_id = ~last;
            default: gnt_id = PORT_IF;
        endcase
    end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one flash read controller between instruction fetch and data memory.
// Optional one-word read buffer enabled by defining FLASH_ARB_LINEBUF_EN.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              err_o,
    output logic              fc_req_o,
    output logic [ADDR_W-1:0] fc_addr_o,
    input  logic              fc_done_i,
    input  logic [DATA_W-1:0] fc_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic              gnt;
    logic              last;
    logic [CNT_W-1:0]  cnt;
    logic              gnt_id;
    logic              gnt_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              resp_go;
    logic              resp_err;
    logic              resp_port;
    logic [DATA_W-1:0] resp_data;

    flash_arb_rr u_rr (
        .req     ({dm_req_i, if_req_i}),
        .last    (last),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign sel_addr = (gnt_id == PORT_DM) ? dm_addr_i : if_addr_i;

`ifdef FLASH_ARB_LINEBUF_EN
    logic [ADDR_W-1:0] lb_tag;
    logic [DATA_W-1:0] lb_data;
    logic              lb_vld;

    // Only genuine flash data fills the buffer; timeouts never reach this branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_vld  <= 1'b0;
            lb_tag  <= '0;
            lb_data <= '0;
        end else if (state == ST_WAIT && fc_done_i) begin
            lb_vld  <= 1'b1;
            lb_tag  <= fc_addr_o;
            lb_data <= fc_rdata_i;
        end
    end

    assign hit      = lb_vld && (lb_tag == sel_addr);
    assign hit_data = lb_data;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // A response is produced either by a buffer hit in IDLE or by completion/timeout in WAIT.
    always_comb begin
        resp_go   = 1'b0;
        resp_err  = 1'b0;
        resp_port = gnt;
        resp_data = DATA_W'(ERR_WORD);
        if (state == ST_IDLE) begin
            resp_go   = gnt_vld && hit;
            resp_port = gnt_id;
            resp_data = hit_data;
        end else if (state == ST_WAIT) begin
            resp_go  = fc_done_i || (cnt == CNT_LAST);
            resp_err = !fc_done_i;
            if (fc_done_i) resp_data = fc_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= PORT_IF;
            last       <= PORT_DM;
            cnt        <= '0;
            fc_req_o   <= 1'b0;
            fc_addr_o  <= '0;
            if_ack_o   <= 1'b0;
            dm_ack_o   <= 1'b0;
            err_o      <= 1'b0;
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
        end else begin
            fc_req_o <= 1'b0;
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            err_o    <= 1'b0;
            if (resp_go) begin
                err_o <= resp_err;
                if (resp_port == PORT_DM) begin
                    dm_ack_o   <= 1'b1;
                    dm_rdata_o <= resp_data;
                end else begin
                    if_ack_o   <= 1'b1;
                    if_rdata_o <= resp_data;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        gnt  <= gnt_id;
                        last <= gnt_id;
                        if (hit) begin
                            state <= ST_RESP;
                        end else begin
                            fc_addr_o <= sel_addr;
                            fc_req_o  <= 1'b1;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (resp_go) state <= ST_RESP;
                    else         cnt   <= cnt + 1'b1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter; exercises the read buffer when FLASH_ARB_LINEBUF_EN is defined.
module tb_flash_arbiter;
    import flash_arb_pkg::*;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic              port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
        logic              hit;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_i, dm_req_i;
    logic [ADDR_W-1:0] if_addr_i, dm_addr_i;
    logic [DATA_W-1:0] if_rdata_o, dm_rdata_o;
    logic              if_ack_o, dm_ack_o, err_o;
    logic              fc_req_o;
    logic [ADDR_W-1:0] fc_addr_o;
    logic              fc_done_i;
    logic [DATA_W-1:0] fc_rdata_i;

    exp_t              exp_q[$];
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    int                n_issue = 0;
    int                issue_c, done_c, ack_c, req_c, n0;
    int                resp_delay;
    logic              resp_en;
    logic [DATA_W-1:0] last_if = '0;
    logic [DATA_W-1:0] last_dm = '0;
    logic [ADDR_W-1:0] pend;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flash_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .err_o(err_o), .fc_req_o(fc_req_o), .fc_addr_o(fc_addr_o),
        .fc_done_i(fc_done_i), .fc_rdata_i(fc_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model(input logic [ADDR_W-1:0] a);
        if (a == 24'h000100) return 32'hDEAD_BEEF;
        return {a[7:0], a} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic raise(input logic port, input logic [ADDR_W-1:0] a);
        if (port == PORT_IF) begin if_req_i = 1'b1; if_addr_i = a; end
        else begin dm_req_i = 1'b1; dm_addr_i = a; end
    endtask

    task automatic push(input logic port, input logic [ADDR_W-1:0] a, input logic err, input logic hit);
        exp_t e;
        e.port = port; e.addr = a; e.err = err; e.hit = hit;
        e.data = err ? ERR_WORD : model(a);
        exp_q.push_back(e);
    endtask

    // Flash controller model plus ack scoreboard, one negedge per loop pass.
    task automatic run(input int want, input int budget);
        int got = 0;
        int cd = -1;
        exp_t e;
        logic [DATA_W-1:0] rd;
        for (int c = 0; c < budget && (want == 0 || got < want); c++) begin
            @(negedge clk);
            fc_done_i = 1'b0;
            if (cd == 0) begin
                fc_done_i = 1'b1; fc_rdata_i = model(pend); done_c = cyc; cd = -1;
            end else if (cd > 0) cd--;
            if (fc_req_o) begin
                n_issue++;
                issue_c = cyc;
                pend = fc_addr_o;
                if (resp_en) cd = resp_delay;
                if (exp_q.size() > 0) begin
                    check_eq("issue_addr", 64'(fc_addr_o), 64'(exp_q[0].addr));
                    check_eq("issue_on_hit", 64'(exp_q[0].hit), 64'd0);
                end
            end
            if (if_ack_o || dm_ack_o) begin
                got++;
                ack_c = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_ack", 64'({if_ack_o, dm_ack_o}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("ack_port", 64'({if_ack_o, dm_ack_o}), (e.port == PORT_IF) ? 64'b10 : 64'b01);
                    rd = (e.port == PORT_IF) ? if_rdata_o : dm_rdata_o;
                    check_eq("rdata", 64'(rd), 64'(e.data));
                    check_eq("err", 64'(err_o), 64'(e.err));
                    if (e.port == PORT_IF) begin
                        check_eq("dm_rdata_hold", 64'(dm_rdata_o), 64'(last_dm));
                        last_if = e.data; if_req_i = 1'b0;
                    end else begin
                        check_eq("if_rdata_hold", 64'(if_rdata_o), 64'(last_if));
                        last_dm = e.data; dm_req_i = 1'b0;
                    end
                    if (e.err) check_eq("timeout_latency", 64'(ack_c - issue_c), 64'(TIMEOUT + 1));
                    else if (!e.hit) check_eq("done_to_ack", 64'(ack_c - done_c), 64'd1);
                end
            end else if (err_o) begin
                check_eq("err_without_ack", 64'(err_o), 64'd0);
            end
        end
        check_eq("ack_count", 64'(got), 64'(want));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_fc_req"}, 64'(fc_req_o), 64'd0);
        check_eq({tag, "_acks"}, 64'({if_ack_o, dm_ack_o}), 64'd0);
        check_eq({tag, "_err"}, 64'(err_o), 64'd0);
        check_eq({tag, "_fc_addr"}, 64'(fc_addr_o), 64'd0);
        check_eq({tag, "_if_rdata"}, 64'(if_rdata_o), 64'd0);
        check_eq({tag, "_dm_rdata"}, 64'(dm_rdata_o), 64'd0);
    endtask

    initial begin
        rst = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0; if_addr_i = '0; dm_addr_i = '0;
        fc_done_i = 1'b0; fc_rdata_i = '0; resp_en = 1'b1; resp_delay = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        run(0, 2);

        // IF alone, single issue with the requested address.
        resp_delay = 5; n0 = n_issue;
        raise(PORT_IF, 24'h000100); push(PORT_IF, 24'h000100, 1'b0, 1'b0);
        run(1, 40);
        check_eq("if_alone_issues", 64'(n_issue - n0), 64'd1);
        run(0, 2);

        // Minimum latency: done sampled on the first WAIT edge.
        resp_delay = 0; req_c = cyc;
        raise(PORT_DM, 24'h000200); push(PORT_DM, 24'h000200, 1'b0, 1'b0);
        run(1, 20);
        check_eq("min_latency", 64'(ack_c - req_c), 64'd3);
        run(0, 2);

        // Repeated ties after a DM grant: IF wins each tie, DM follows.
        for (int r = 0; r < 4; r++) begin
            resp_delay = r;
            raise(PORT_IF, ADDR_W'(24'h001000 + r * 4)); raise(PORT_DM, ADDR_W'(24'h002000 + r * 4));
            push(PORT_IF, ADDR_W'(24'h001000 + r * 4), 1'b0, 1'b0);
            push(PORT_DM, ADDR_W'(24'h002000 + r * 4), 1'b0, 1'b0);
            run(2, 60);
            run(0, 1);
        end

        // After an IF grant, a tie goes to DM.
        resp_delay = 1;
        raise(PORT_IF, 24'h003000); push(PORT_IF, 24'h003000, 1'b0, 1'b0);
        run(1, 30); run(0, 1);
        raise(PORT_IF, 24'h003004); raise(PORT_DM, 24'h003008);
        push(PORT_DM, 24'h003008, 1'b0, 1'b0); push(PORT_IF, 24'h003004, 1'b0, 1'b0);
        run(2, 60); run(0, 2);

        // Timeout with no done, then a stray done in IDLE.
        resp_en = 1'b0;
        raise(PORT_DM, 24'h000300); push(PORT_DM, 24'h000300, 1'b1, 1'b0);
        run(1, 60); run(0, 2);
        @(negedge clk); fc_done_i = 1'b1; fc_rdata_i = 32'h0BAD_0BAD;
        run(0, 8);
        resp_en = 1'b1;

        // Done on the very cycle the counter expires: data wins.
        resp_delay = TIMEOUT - 1;
        raise(PORT_DM, 24'h000400); push(PORT_DM, 24'h000400, 1'b0, 1'b0);
        run(1, 60);
        check_eq("tie_timeout_latency", 64'(ack_c - issue_c), 64'(TIMEOUT + 1));
        run(0, 2);

        // Reset in WAIT abandons the transfer; a stray done afterwards is ignored.
        resp_en = 1'b0;
        raise(PORT_IF, 24'h000500);
        run(0, 4);
        rst = 1'b1;
        #1 check_zero("rst_in_wait");
        if_req_i = 1'b0; last_if = '0; last_dm = '0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); fc_done_i = 1'b1; fc_rdata_i = 32'h5555_AAAA;
        run(0, 8);
        resp_en = 1'b1; resp_delay = 2;
        raise(PORT_IF, 24'h000600); push(PORT_IF, 24'h000600, 1'b0, 1'b0);
        run(1, 30); run(0, 2);

        // Re-read of the same word, then a neighbouring word.
        resp_delay = 1;
        raise(PORT_IF, 24'h000040); push(PORT_IF, 24'h000040, 1'b0, 1'b0);
        run(1, 30); run(0, 2);
        n0 = n_issue; req_c = cyc;
        raise(PORT_IF, 24'h000040);
`ifdef FLASH_ARB_LINEBUF_EN
        push(PORT_IF, 24'h000040, 1'b0, 1'b1);
        run(1, 10);
        check_eq("hit_issues", 64'(n_issue - n0), 64'd0);
        check_eq("hit_latency", 64'(ack_c - req_c), 64'd1);
`else
        push(PORT_IF, 24'h000040, 1'b0, 1'b0);
        run(1, 30);
        check_eq("reread_issues", 64'(n_issue - n0), 64'd1);
`endif
        run(0, 2);
        n0 = n_issue;
        raise(PORT_DM, 24'h000044); push(PORT_DM, 24'h000044, 1'b0, 1'b0);
        run(1, 30);
        check_eq("neighbour_issues", 64'(n_issue - n0), 64'd1);
        run(0, 2);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
